// File: rtl/fml_vtx_trace_capture_pkg.sv
// Shared definitions for the formal trace capture block:
// FSM encodings, default sizes and the per-slot memory record.
package fml_vtx_trace_capture_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  localparam int DEF_NTXN    = 4;
  localparam int DEF_NREGS   = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef struct packed {
    logic        cen;
    logic        wen;
    logic        error;
    logic [3:0]  ben;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  localparam txn_t TXN_NONE = '0;

endpackage

// File: rtl/fml_vtx_trace_capture_shadow_crf.sv
// Shadow copy of the coprocessor register file, fed by the
// snooped CPR write port, with a flat read-out of every register.
module fml_vtx_trace_capture_shadow_crf
  import fml_vtx_trace_capture_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [3:0]            waddr,
  input  logic [31:0]           wdata,
  output logic [32*NREGS-1:0]   rd_flat
);

  logic [31:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wen) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_rd
    assign rd_flat[32*g +: 32] = regs[g];
  end

endmodule

// File: rtl/fml_vtx_trace_capture.sv
// Builds one trace record per retired coprocessor instruction
// from the issue/response handshakes, CPR writes and memory bus.
module fml_vtx_trace_capture
  import fml_vtx_trace_capture_pkg::*;
#(
  parameter int NTXN    = DEF_NTXN,
  parameter int NREGS   = DEF_NREGS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 vtx_clk,
  input  logic                 vtx_reset,
  input  logic                 cop_insn_valid,
  output logic                 cop_insn_ready,
  input  logic [31:0]          cop_insn_enc,
  input  logic [31:0]          cop_insn_rs1,
  input  logic [31:0]          cop_rand,
  input  logic                 cop_rsp_valid,
  output logic                 cop_rsp_ready,
  input  logic [2:0]           cop_rsp_result,
  input  logic                 cop_rsp_wen,
  input  logic [4:0]           cop_rsp_waddr,
  input  logic [31:0]          cop_rsp_wdata,
  input  logic                 crf_wen,
  input  logic [3:0]           crf_waddr,
  input  logic [31:0]          crf_wdata,
  input  logic                 mem_cen,
  input  logic                 mem_wen,
  input  logic                 mem_gnt,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic [3:0]           mem_ben,
  input  logic                 mem_error,
  output logic                 vtx_valid,
  output logic [31:0]          vtx_instr_enc,
  output logic [31:0]          vtx_instr_rs1,
  output logic [31:0]          vtx_rand_sample,
  output logic [31:0]          vtx_instr_wdata,
  output logic [2:0]           vtx_instr_result,
  output logic [4:0]           vtx_instr_waddr,
  output logic                 vtx_instr_wen,
  output logic [32*NREGS-1:0]  vtx_cprs_pre,
  output logic [32*NREGS-1:0]  vtx_cprs_post,
  output logic [NTXN-1:0]      vtx_mem_cen,
  output logic [NTXN-1:0]      vtx_mem_wen,
  output logic [NTXN-1:0]      vtx_mem_error,
  output logic [32*NTXN-1:0]   vtx_mem_addr,
  output logic [32*NTXN-1:0]   vtx_mem_wdata,
  output logic [32*NTXN-1:0]   vtx_mem_rdata,
  output logic [4*NTXN-1:0]    vtx_mem_ben,
  output logic                 vtx_timeout,
  output logic                 vtx_txn_overflow
);

  localparam int CW = $clog2(NTXN + 1);
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [1:0]           state;
  logic [CW-1:0]        txn_cnt;
  logic [TW-1:0]        tmo_cnt;
  txn_t                 slot [NTXN];
  logic [32*NREGS-1:0]  crf_flat;
  logic [32*NREGS-1:0]  post_nxt;
  logic                 issue;
  logic                 rsp_hs;
  logic                 mem_hit;
  logic                 tmo_hit;

  fml_vtx_trace_capture_shadow_crf #(
    .NREGS (NREGS)
  ) u_crf (
    .clk     (vtx_clk),
    .rst     (vtx_reset),
    .wen     (crf_wen),
    .waddr   (crf_waddr),
    .wdata   (crf_wdata),
    .rd_flat (crf_flat)
  );

  assign cop_insn_ready = (state == ST_IDLE) & ~vtx_reset;
  assign cop_rsp_ready  = (state == ST_BUSY) & ~vtx_reset;

  assign issue   = cop_insn_valid && (state == ST_IDLE);
  assign rsp_hs  = cop_rsp_valid && (state == ST_BUSY);
  assign mem_hit = mem_cen && mem_gnt;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Post snapshot must include a CPR write landing in the final BUSY cycle.
  always_comb begin
    post_nxt = crf_flat;
    if (crf_wen)
      post_nxt[{crf_waddr, 5'b0} +: 32] = crf_wdata;
  end

  always_ff @(posedge vtx_clk or posedge vtx_reset) begin
    if (vtx_reset) begin
      state            <= ST_IDLE;
      txn_cnt          <= '0;
      tmo_cnt          <= '0;
      vtx_valid        <= 1'b0;
      vtx_instr_enc    <= '0;
      vtx_instr_rs1    <= '0;
      vtx_rand_sample  <= '0;
      vtx_instr_wdata  <= '0;
      vtx_instr_result <= '0;
      vtx_instr_waddr  <= '0;
      vtx_instr_wen    <= 1'b0;
      vtx_cprs_pre     <= '0;
      vtx_cprs_post    <= '0;
      vtx_timeout      <= 1'b0;
      vtx_txn_overflow <= 1'b0;
      for (int i = 0; i < NTXN; i++)
        slot[i] <= TXN_NONE;
    end else begin
      vtx_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            state            <= ST_BUSY;
            txn_cnt          <= '0;
            tmo_cnt          <= '0;
            vtx_instr_enc    <= cop_insn_enc;
            vtx_instr_rs1    <= cop_insn_rs1;
            vtx_rand_sample  <= cop_rand;
            vtx_cprs_pre     <= crf_flat;
            vtx_instr_wdata  <= '0;
            vtx_instr_result <= '0;
            vtx_instr_waddr  <= '0;
            vtx_instr_wen    <= 1'b0;
            vtx_timeout      <= 1'b0;
            vtx_txn_overflow <= 1'b0;
            for (int i = 0; i < NTXN; i++)
              slot[i] <= TXN_NONE;
          end
        end
        ST_BUSY: begin
          if (mem_hit) begin
            if (txn_cnt == CW'(NTXN)) begin
              vtx_txn_overflow <= 1'b1;
            end else begin
              for (int i = 0; i < NTXN; i++)
                if (txn_cnt == CW'(i))
                  slot[i] <= '{cen:   1'b1,
                               wen:   mem_wen,
                               error: mem_error,
                               ben:   mem_ben,
                               addr:  mem_addr,
                               wdata: mem_wdata,
                               rdata: mem_rdata};
              txn_cnt <= txn_cnt + CW'(1);
            end
          end
          if (rsp_hs) begin
            state            <= ST_EMIT;
            vtx_valid        <= 1'b1;
            vtx_cprs_post    <= post_nxt;
            vtx_instr_result <= cop_rsp_result;
            vtx_instr_wen    <= cop_rsp_wen;
            vtx_instr_waddr  <= cop_rsp_waddr;
            vtx_instr_wdata  <= cop_rsp_wdata;
          end else if (tmo_hit) begin
            state            <= ST_EMIT;
            vtx_valid        <= 1'b1;
            vtx_cprs_post    <= post_nxt;
            vtx_timeout      <= 1'b1;
            vtx_instr_result <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_EMIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NTXN; g++) begin : g_slot
    assign vtx_mem_cen[g]            = slot[g].cen;
    assign vtx_mem_wen[g]            = slot[g].wen;
    assign vtx_mem_error[g]          = slot[g].error;
    assign vtx_mem_ben[4*g +: 4]     = slot[g].ben;
    assign vtx_mem_addr[32*g +: 32]  = slot[g].addr;
    assign vtx_mem_wdata[32*g +: 32] = slot[g].wdata;
    assign vtx_mem_rdata[32*g +: 32] = slot[g].rdata;
  end

endmodule

// File: tb/tb_fml_vtx_trace_capture.sv
// Scoreboard bench for fml_vtx_trace_capture: directed cases plus
// randomized instructions checked against a cycle-level trace model.
module tb_fml_vtx_trace_capture;

  logic         vtx_clk = 1'b0;
  logic         vtx_reset;
  logic         cop_insn_valid;
  logic         cop_insn_ready;
  logic [31:0]  cop_insn_enc;
  logic [31:0]  cop_insn_rs1;
  logic [31:0]  cop_rand;
  logic         cop_rsp_valid;
  logic         cop_rsp_ready;
  logic [2:0]   cop_rsp_result;
  logic         cop_rsp_wen;
  logic [4:0]   cop_rsp_waddr;
  logic [31:0]  cop_rsp_wdata;
  logic         crf_wen;
  logic [3:0]   crf_waddr;
  logic [31:0]  crf_wdata;
  logic         mem_cen, mem_wen, mem_gnt, mem_error;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_ben;
  logic         vtx_valid;
  logic [31:0]  vtx_instr_enc, vtx_instr_rs1, vtx_rand_sample;
  logic [31:0]  vtx_instr_wdata;
  logic [2:0]   vtx_instr_result;
  logic [4:0]   vtx_instr_waddr;
  logic         vtx_instr_wen;
  logic [511:0] vtx_cprs_pre, vtx_cprs_post;
  logic [3:0]   vtx_mem_cen, vtx_mem_wen, vtx_mem_error;
  logic [127:0] vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata;
  logic [15:0]  vtx_mem_ben;
  logic         vtx_timeout, vtx_txn_overflow;

  fml_vtx_trace_capture dut (
    .vtx_clk          (vtx_clk),
    .vtx_reset        (vtx_reset),
    .cop_insn_valid   (cop_insn_valid),
    .cop_insn_ready   (cop_insn_ready),
    .cop_insn_enc     (cop_insn_enc),
    .cop_insn_rs1     (cop_insn_rs1),
    .cop_rand         (cop_rand),
    .cop_rsp_valid    (cop_rsp_valid),
    .cop_rsp_ready    (cop_rsp_ready),
    .cop_rsp_result   (cop_rsp_result),
    .cop_rsp_wen      (cop_rsp_wen),
    .cop_rsp_waddr    (cop_rsp_waddr),
    .cop_rsp_wdata    (cop_rsp_wdata),
    .crf_wen          (crf_wen),
    .crf_waddr        (crf_waddr),
    .crf_wdata        (crf_wdata),
    .mem_cen          (mem_cen),
    .mem_wen          (mem_wen),
    .mem_gnt          (mem_gnt),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ben          (mem_ben),
    .mem_error        (mem_error),
    .vtx_valid        (vtx_valid),
    .vtx_instr_enc    (vtx_instr_enc),
    .vtx_instr_rs1    (vtx_instr_rs1),
    .vtx_rand_sample  (vtx_rand_sample),
    .vtx_instr_wdata  (vtx_instr_wdata),
    .vtx_instr_result (vtx_instr_result),
    .vtx_instr_waddr  (vtx_instr_waddr),
    .vtx_instr_wen    (vtx_instr_wen),
    .vtx_cprs_pre     (vtx_cprs_pre),
    .vtx_cprs_post    (vtx_cprs_post),
    .vtx_mem_cen      (vtx_mem_cen),
    .vtx_mem_wen      (vtx_mem_wen),
    .vtx_mem_error    (vtx_mem_error),
    .vtx_mem_addr     (vtx_mem_addr),
    .vtx_mem_wdata    (vtx_mem_wdata),
    .vtx_mem_rdata    (vtx_mem_rdata),
    .vtx_mem_ben      (vtx_mem_ben),
    .vtx_timeout      (vtx_timeout),
    .vtx_txn_overflow (vtx_txn_overflow)
  );

  always #5 vtx_clk = ~vtx_clk;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [31:0]  enc;
    logic [31:0]  rs1;
    logic [31:0]  rnd;
    logic [2:0]   res;
    logic         wen;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [511:0] pre;
    logic [511:0] post;
    logic [3:0]   mcen;
    logic [3:0]   mwen;
    logic [3:0]   merr;
    logic [127:0] maddr;
    logic [127:0] mwd;
    logic [127:0] mrd;
    logic [15:0]  mben;
    logic         tmo;
    logic         ovf;
  } rec_t;

  rec_t        sbq [$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] m_regs [16];
  logic [31:0] mem_plan [$];
  bit          d_iss_en = 0;
  logic [3:0]  d_iss_a;
  logic [31:0] d_iss_d;
  bit          d_rsp_en = 0;
  logic [3:0]  d_rsp_a;
  logic [31:0] d_rsp_d;

  function automatic void chk(input string nm,
                              input logic [511:0] act,
                              input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [511:0] flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++)
      f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  // Every clock edge goes through here so the model and cycle count track the DUT.
  task automatic step();
    @(posedge vtx_clk);
    cyc++;
    if (vtx_reset)
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
    else if (crf_wen)
      m_regs[crf_waddr] = crf_wdata;
  endtask

  task automatic noise(input bit quiet, input bit busy);
    cop_insn_valid = 1'b0;
    if (quiet) begin
      crf_wen       = 1'b0;
      mem_cen       = 1'b0;
      mem_gnt       = 1'b0;
      cop_rsp_valid = 1'b0;
    end else begin
      crf_wen        = ($urandom_range(0, 2) == 0);
      crf_waddr      = 4'($urandom);
      crf_wdata      = $urandom;
      mem_cen        = ($urandom_range(0, 3) != 0);
      mem_gnt        = ($urandom_range(0, 2) != 0);
      mem_wen        = 1'($urandom_range(0, 1));
      mem_addr       = $urandom;
      mem_wdata      = $urandom;
      mem_rdata      = $urandom;
      mem_ben        = 4'($urandom);
      mem_error      = ($urandom_range(0, 7) == 0);
      cop_rsp_valid  = busy ? 1'b0 : 1'($urandom_range(0, 1));
      cop_rsp_result = 3'($urandom);
      cop_rsp_wen    = 1'($urandom_range(0, 1));
      cop_rsp_waddr  = 5'($urandom);
      cop_rsp_wdata  = $urandom;
    end
  endtask

  task automatic do_insn(input bit quiet, input int nbusy, input bit rsp,
                         input logic [31:0] enc, input logic [31:0] rs1,
                         input logic [31:0] rnd, input logic [2:0] res,
                         input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd);
    rec_t e;
    int   n;
    e = '0;
    n = 0;
    @(negedge vtx_clk);
    chk("insn_ready_idle", cop_insn_ready, 1'b1);
    noise(quiet, 1'b0);
    if (d_iss_en) begin
      crf_wen = 1'b1; crf_waddr = d_iss_a; crf_wdata = d_iss_d;
      d_iss_en = 0;
    end
    cop_insn_valid = 1'b1;
    cop_insn_enc   = enc;
    cop_insn_rs1   = rs1;
    cop_rand       = rnd;
    e.pre = flat();
    e.enc = enc; e.rs1 = rs1; e.rnd = rnd;
    step();
    for (int k = 1; k <= nbusy; k++) begin
      @(negedge vtx_clk);
      noise(quiet, 1'b1);
      if (!quiet) cop_insn_valid = 1'($urandom_range(0, 1));
      if (mem_plan.size() > 0) begin
        mem_cen = 1'b1; mem_gnt = 1'b1; mem_wen = 1'b1;
        mem_addr = mem_plan.pop_front();
        mem_wdata = $urandom; mem_rdata = $urandom;
        mem_ben = 4'hF; mem_error = 1'b0;
      end
      if (k == nbusy && rsp) begin
        cop_rsp_valid  = 1'b1;
        cop_rsp_result = res;
        cop_rsp_wen    = wen;
        cop_rsp_waddr  = wa;
        cop_rsp_wdata  = wd;
        if (d_rsp_en) begin
          crf_wen = 1'b1; crf_waddr = d_rsp_a; crf_wdata = d_rsp_d;
          d_rsp_en = 0;
        end
      end
      if (mem_cen && mem_gnt) begin
        if (n < 4) begin
          e.mcen[n]          = 1'b1;
          e.mwen[n]          = mem_wen;
          e.merr[n]          = mem_error;
          e.mben[4*n +: 4]   = mem_ben;
          e.maddr[32*n +: 32] = mem_addr;
          e.mwd[32*n +: 32]  = mem_wdata;
          e.mrd[32*n +: 32]  = mem_rdata;
        end else begin
          e.ovf = 1'b1;
        end
        n++;
      end
      step();
    end
    e.post = flat();
    e.cyc  = cyc;
    e.tmo  = !rsp;
    if (rsp) begin
      e.res = res; e.wen = wen; e.wa = wa; e.wd = wd;
    end
    sbq.push_back(e);
    @(negedge vtx_clk);
    chk("insn_ready_emit", cop_insn_ready, 1'b0);
    chk("rsp_ready_emit", cop_rsp_ready, 1'b0);
    noise(quiet, 1'b0);
    if (!quiet) cop_insn_valid = 1'($urandom_range(0, 1));
    step();
    if (!quiet)
      repeat ($urandom_range(0, 2)) begin
        @(negedge vtx_clk);
        noise(1'b0, 1'b0);
        step();
      end
  endtask

  task automatic idle_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge vtx_clk);
    noise(1'b1, 1'b0);
    crf_wen = 1'b1; crf_waddr = a; crf_wdata = d;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, vtx_valid, '0);
    chk({tag, "_enc"}, vtx_instr_enc, '0);
    chk({tag, "_rs1"}, vtx_instr_rs1, '0);
    chk({tag, "_rand"}, vtx_rand_sample, '0);
    chk({tag, "_wb"}, {vtx_instr_result, vtx_instr_wen,
                       vtx_instr_waddr, vtx_instr_wdata}, '0);
    chk({tag, "_pre"}, vtx_cprs_pre, '0);
    chk({tag, "_post"}, vtx_cprs_post, '0);
    chk({tag, "_mem"}, {vtx_mem_cen, vtx_mem_wen, vtx_mem_error,
                        vtx_mem_addr, vtx_mem_wdata, vtx_mem_rdata,
                        vtx_mem_ben}, '0);
    chk({tag, "_flags"}, {vtx_timeout, vtx_txn_overflow}, '0);
    chk({tag, "_ready"}, cop_insn_ready, 1'b1);
  endtask

  always @(negedge vtx_clk) begin
    rec_t m;
    if (vtx_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got record at cycle %0d expected none",
                 cyc);
      end else begin
        m = sbq.pop_front();
        chk("emit_cycle", 32'(cyc), m.cyc);
        chk("enc", vtx_instr_enc, m.enc);
        chk("rs1", vtx_instr_rs1, m.rs1);
        chk("rand", vtx_rand_sample, m.rnd);
        chk("result", vtx_instr_result, m.res);
        chk("wb_wen", vtx_instr_wen, m.wen);
        chk("wb_waddr", vtx_instr_waddr, m.wa);
        chk("wb_wdata", vtx_instr_wdata, m.wd);
        chk("cprs_pre", vtx_cprs_pre, m.pre);
        chk("cprs_post", vtx_cprs_post, m.post);
        chk("mem_cen", vtx_mem_cen, m.mcen);
        chk("mem_wen", vtx_mem_wen, m.mwen);
        chk("mem_error", vtx_mem_error, m.merr);
        chk("mem_addr", vtx_mem_addr, m.maddr);
        chk("mem_wdata", vtx_mem_wdata, m.mwd);
        chk("mem_rdata", vtx_mem_rdata, m.mrd);
        chk("mem_ben", vtx_mem_ben, m.mben);
        chk("timeout", vtx_timeout, m.tmo);
        chk("overflow", vtx_txn_overflow, m.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got no completion expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit rsp;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    vtx_reset = 1'b1;
    cop_insn_enc = '0; cop_insn_rs1 = '0; cop_rand = '0;
    cop_rsp_result = '0; cop_rsp_wen = 1'b0;
    cop_rsp_waddr = '0; cop_rsp_wdata = '0;
    crf_waddr = '0; crf_wdata = '0;
    mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
    mem_rdata = '0; mem_ben = '0; mem_error = 1'b0;
    noise(1'b1, 1'b0);
    step();
    step();
    @(negedge vtx_clk);
    vtx_reset = 1'b0;
    step();
    @(negedge vtx_clk);
    chk_all_zero("reset");

    idle_write(4'd3, 32'hDEADBEEF);
    do_insn(1'b1, 2, 1'b1, 32'h0000_302B, 32'h1234_5678, 32'hCAFE_0001,
            3'd0, 1'b1, 5'd5, 32'h11);

    d_iss_en = 1; d_iss_a = 4'd7; d_iss_d = 32'hA5;
    do_insn(1'b1, 1, 1'b1, 32'h0000_702B, 32'h1, 32'h2,
            3'd1, 1'b0, 5'd0, 32'h0);

    d_rsp_en = 1; d_rsp_a = 4'd2; d_rsp_d = 32'h1;
    do_insn(1'b1, 3, 1'b1, 32'h0000_202B, 32'h3, 32'h4,
            3'd2, 1'b1, 5'd9, 32'hFACE);

    for (int i = 0; i < 5; i++) mem_plan.push_back(32'h100 + 32'(4 * i));
    do_insn(1'b1, 6, 1'b1, 32'h0000_402B, 32'h5, 32'h6,
            3'd3, 1'b1, 5'd1, 32'h22);

    do_insn(1'b1, 64, 1'b0, 32'h0000_502B, 32'h7, 32'h8,
            3'd0, 1'b0, 5'd0, 32'h0);

    for (int t = 0; t < 50; t++) begin
      rsp = ($urandom_range(0, 9) != 0);
      do_insn(1'b0, rsp ? int'($urandom_range(1, 8)) : 64, rsp,
              $urandom, $urandom, $urandom, 3'($urandom),
              1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    end

    @(negedge vtx_clk);
    noise(1'b1, 1'b0);
    crf_wen = 1'b1; crf_waddr = 4'd9; crf_wdata = 32'h1234;
    cop_insn_valid = 1'b1;
    cop_insn_enc = 32'hBAD0_002B;
    step();
    @(negedge vtx_clk);
    noise(1'b1, 1'b1);
    mem_cen = 1'b1; mem_gnt = 1'b1; mem_addr = 32'h200;
    step();
    @(negedge vtx_clk);
    noise(1'b1, 1'b1);
    vtx_reset = 1'b1;
    step();
    @(negedge vtx_clk);
    vtx_reset = 1'b0;
    #1;
    chk_all_zero("midreset");

    do_insn(1'b1, 2, 1'b1, 32'h0000_602B, 32'h9, 32'hA,
            3'd4, 1'b1, 5'd31, 32'hFFFF_FFFF);

    for (int t = 0; t < 10; t++)
      do_insn(1'b0, int'($urandom_range(1, 5)), 1'b1,
              $urandom, $urandom, $urandom, 3'($urandom),
              1'($urandom_range(0, 1)), 5'($urandom), $urandom);

    repeat (3) begin
      @(negedge vtx_clk);
      noise(1'b1, 1'b0);
      step();
    end
    @(negedge vtx_clk);
    chk("pending_records", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
